systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/npu_pkg.sv | 5 +
 rtl/systolic_perf_cnt.sv | 22 ++
 rtl/systolic_ctrl.sv | 134 +++++++++++++
 tb/tb_systolic_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared FSM state encoding and perf counter width for the systolic array controller
package npu_pkg;
  localparam int PERF_W = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, COMPUTE, DRAIN, OUTPUT, DONE} state_t;
endpackage

// File: rtl/systolic_perf_cnt.sv
// systolic_perf_cnt: saturating busy-cycle and stall counters, cleared when a tile is launched
module systolic_perf_cnt
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              busy,
  input  logic              stall,
  output logic [PERF_W-1:0] cycles,
  output logic [PERF_W-1:0] stalls
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cycles <= '0;
      stalls <= '0;
    end else begin
      if (busy && !(&cycles)) cycles <= cycles + 1'b1;
      if (stall && !(&stalls)) stalls <= stalls + 1'b1;
    end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile sequencer for a ROWS x COLS systolic array (clear, weight load, compute, drain, readout).
// Define SYSTOLIC_CTRL_PERF_EN to enable the perf_cycles/perf_stalls counters; otherwise they read 0.
module systolic_ctrl
  import npu_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_WIDTH = 16,
  localparam int CW     = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_WIDTH-1:0] cfg_k,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               wt_req,
  input  logic               wt_valid,
  output logic               act_ready,
  input  logic               act_valid,
  output logic               act_zero,
  output logic               pe_clear_acc,
  output logic               pe_enable,
  output logic [ROWS-1:0]    pe_load_weight,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CW-1:0]      res_col,
  output logic [PERF_W-1:0]  perf_cycles,
  output logic [PERF_W-1:0]  perf_stalls
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int DL = ROWS + COLS - 2;
  localparam int DW = DL > 1 ? $clog2(DL) : 1;
  state_t state;
  logic [RW-1:0] row;
  logic [K_WIDTH-1:0] beat, k_lat;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] col;
  logic err_q, zdone_q, abort_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      beat    <= '0;
      dcnt    <= '0;
      col     <= '0;
      k_lat   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
      abort_q <= 1'b0;
      if (state != IDLE && abort) begin
        state   <= IDLE;
        abort_q <= 1'b1;
        row     <= '0;
        beat    <= '0;
        dcnt    <= '0;
        col     <= '0;
      end else begin
        case (state)
          IDLE:
            if (start) begin
              if (cfg_k == '0) begin
                err_q   <= 1'b1;
                zdone_q <= 1'b1;
              end else begin
                k_lat <= cfg_k;
                state <= CLEAR;
              end
            end
          CLEAR: begin
            row   <= '0;
            state <= LOAD_W;
          end
          LOAD_W:
            if (wt_valid) begin
              row   <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
              state <= row == RW'(ROWS - 1) ? COMPUTE : LOAD_W;
            end
          COMPUTE:
            if (act_valid) begin
              beat  <= beat == k_lat - 1'b1 ? '0 : beat + 1'b1;
              state <= beat != k_lat - 1'b1 ? COMPUTE : DL == 0 ? OUTPUT : DRAIN;
            end
          DRAIN: begin
            dcnt  <= dcnt == DW'(DL - 1) ? '0 : dcnt + 1'b1;
            state <= dcnt == DW'(DL - 1) ? OUTPUT : DRAIN;
          end
          OUTPUT:
            if (res_ready) begin
              col   <= col == CW'(COLS - 1) ? '0 : col + 1'b1;
              state <= col == CW'(COLS - 1) ? DONE : OUTPUT;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
  // abort_q supplies the post-abort clear pulse while the FSM already sits in IDLE
  always_comb begin
    busy           = state != IDLE;
    done           = state == DONE || zdone_q;
    err            = err_q;
    wt_req         = state == LOAD_W;
    pe_load_weight = (state == LOAD_W && wt_valid) ? ROWS'(1) << row : '0;
    act_ready      = state == COMPUTE;
    pe_enable      = (state == COMPUTE && act_valid) || state == DRAIN;
    act_zero       = state == DRAIN;
    pe_clear_acc   = state == CLEAR || abort_q;
    res_valid      = state == OUTPUT;
    res_col        = col;
  end
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic stall;
  assign stall = (state == LOAD_W && !wt_valid) || (state == COMPUTE && !act_valid);
  systolic_perf_cnt u_perf (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE && start && cfg_k != '0),
    .busy   (busy),
    .stall  (stall),
    .cycles (perf_cycles),
    .stalls (perf_stalls)
  );
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed checks of the tile sequence, err, stalls, abort, readout back-pressure and reset
module tb_systolic_ctrl;
  logic clk, rst, start, abort, wt_valid, act_valid, res_ready;
  logic [15:0] cfg_k;
  logic busy, done, err, wt_req, act_ready, act_zero, pe_clear_acc, pe_enable, res_valid;
  logic [3:0] pe_load_weight;
  logic [1:0] res_col;
  logic [31:0] perf_cycles, perf_stalls;
  logic [14:0] vec;
  int passed = 0, total = 0;
`ifdef SYSTOLIC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  systolic_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .abort(abort),
    .busy(busy), .done(done), .err(err), .wt_req(wt_req), .wt_valid(wt_valid),
    .act_ready(act_ready), .act_valid(act_valid), .act_zero(act_zero),
    .pe_clear_acc(pe_clear_acc), .pe_enable(pe_enable), .pe_load_weight(pe_load_weight),
    .res_valid(res_valid), .res_ready(res_ready), .res_col(res_col),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  // bit order: busy done err wt_req act_ready act_zero clear enable load[3:0] res_valid res_col[1:0]
  assign vec = {busy, done, err, wt_req, act_ready, act_zero, pe_clear_acc, pe_enable,
                pe_load_weight, res_valid, res_col};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // nominal tile with cfg_k=3, start in cycle 0; h = extra readout stall cycles at res_col=2
  function automatic logic [14:0] expv(input int c, input int h);
    logic [3:0] ld;
    logic [1:0] col;
    ld  = (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'd0;
    col = (c < 15 || c > 18 + h) ? 2'd0 : c <= 16 ? 2'(c - 15) : c <= 17 + h ? 2'd2 : 2'd3;
    return {c >= 1 && c <= 19 + h, c == 19 + h, 1'b0, c >= 2 && c <= 5, c >= 6 && c <= 8,
            c >= 9 && c <= 14, c == 1, c >= 6 && c <= 14, ld, c >= 15 && c <= 18 + h, col};
  endfunction

  task automatic run_seq(input int h, input string tag);
    for (int c = 0; c <= 21 + h; c++) begin
      start     = (c == 0) || (c == 10);
      cfg_k     = (c == 0) ? 16'd3 : 16'd9;
      res_ready = !(c >= 17 && c < 17 + h);
      #1;
      chk($sformatf("%s c%0d", tag, c), 32'(vec), 32'(expv(c, h)));
      tick();
    end
    start     = 1'b0;
    res_ready = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_k = 16'd0;
    wt_valid = 1'b1; act_valid = 1'b1; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset vec", 32'(vec), 32'd0);
    chk("reset perf_cycles", perf_cycles, 32'd0);
    chk("reset perf_stalls", perf_stalls, 32'd0);
    rst = 1'b0;
    tick();

    run_seq(0, "nominal");
    chk("nominal perf_cycles", perf_cycles, PERF ? 32'd19 : 32'd0);
    chk("nominal perf_stalls", perf_stalls, 32'd0);

    start = 1'b1; cfg_k = 16'd0;
    #1;
    chk("kzero c0", 32'(vec), 32'd0);
    tick();
    start = 1'b0;
    chk("kzero c1 err+done", 32'(vec), 32'h3000);
    tick();
    chk("kzero c2", 32'(vec), 32'd0);

    start = 1'b1; cfg_k = 16'd3;
    tick();
    start = 1'b0;
    tick();
    for (int c = 2; c <= 9; c++) begin
      wt_valid = c[0];
      #1;
      chk($sformatf("wtstall load c%0d", c), 32'(pe_load_weight),
          wt_valid ? 32'(1 << ((c - 3) / 2)) : 32'd0);
      chk($sformatf("wtstall wt_req c%0d", c), 32'(wt_req), 32'd1);
      tick();
    end
    wt_valid = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("wtstall done seen", 32'(done), 32'd1);
    tick();
    chk("wtstall perf_stalls", perf_stalls, PERF ? 32'd4 : 32'd0);
    chk("wtstall perf_cycles", perf_cycles, PERF ? 32'd23 : 32'd0);
    chk("wtstall idle", 32'(vec), 32'd0);

    for (int c = 0; c <= 11; c++) begin
      start = (c == 0);
      cfg_k = 16'd3;
      abort = (c == 7) || (c == 9) || (c == 10);
      #1;
      chk($sformatf("abort c%0d", c), 32'(vec),
          c <= 7 ? 32'(expv(c, 0)) : c == 8 ? 32'h0100 : 32'd0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    run_seq(0, "restart");

    run_seq(3, "backpressure");

    for (int c = 0; c <= 10; c++) begin
      start = (c == 0);
      cfg_k = 16'd3;
      rst   = (c == 10);
      #1;
      chk($sformatf("drainrst c%0d", c), 32'(vec), 32'(expv(c, 0)));
      tick();
    end
    rst = 1'b0;
    chk("drainrst perf_cycles", perf_cycles, 32'd0);
    chk("drainrst perf_stalls", perf_stalls, 32'd0);
    run_seq(0, "postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
